// File: rtl/addertree_ctrl_if.sv
// Valid/ready handshakes on both sides of the adder-tree sequencer:
// beats in from the MAC issue logic, finished pixels out to the buffer writer.
interface addertree_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (output in_valid, input in_ready, input out_valid, output out_ready);
  modport slave  (input in_valid, output in_ready, output out_valid, input out_ready);
endinterface

// File: rtl/addertree_ctrl.sv
// Sequencer for the pipelined adder tree: tracks beats, drives stage/accumulator enables.
// Optional cycle counters (perf_active_o, perf_stall_o) with `define ADDERTREE_CTRL_PERF_EN.
module addertree_ctrl #(
  parameter int STAGES = 3,
  parameter int PASS_W = 8,
  parameter int OUT_W  = 12
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [PASS_W-1:0] cfg_passes_i,
  input  logic [OUT_W-1:0]  cfg_outputs_i,
  addertree_ctrl_if.slave   hs,
  output logic [STAGES-1:0] stg_en_o,
  output logic              acc_clr_o,
  output logic              acc_en_o,
  output logic              busy_o,
  output logic              done_o
`ifdef ADDERTREE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_active_o,
  output logic [31:0]       perf_stall_o
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [PASS_W-1:0] PASS_ONE = {{(PASS_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0]  OUT_ONE  = {{(OUT_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [PASS_W-1:0] beat_q, beat_d;
  logic [OUT_W-1:0]  outputs_q, outputs_d;
  logic [OUT_W-1:0]  pix_q, pix_d;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] first_q, first_d;
  logic [STAGES-1:0] last_q, last_d;
  logic              out_valid_q, out_valid_d;

  logic kill;
  logic stall;
  logic advance;
  logic accept;
  logic exitBeat;
  logic lastOfPixel;
  logic finalBeat;
  logic jobDone;

  // Reset low is treated like abort so nothing is accepted or completed that cycle.
  assign kill        = abort_i | ~reset_n_i;
  assign stall       = out_valid_q & ~hs.out_ready;
  assign advance     = ~stall;
  assign hs.in_ready = (state_q == RUN) & advance & ~kill;
  assign accept      = hs.in_valid & hs.in_ready;
  assign exitBeat    = vld_q[STAGES-1] & advance;
  assign lastOfPixel = (beat_q == passes_q - PASS_ONE);
  assign finalBeat   = accept & lastOfPixel & (pix_q == outputs_q - OUT_ONE);
  assign jobDone     = (state_q == DRAIN) & ~|vld_q & (~out_valid_q | hs.out_ready) & ~kill;

  assign hs.out_valid = out_valid_q;
  assign acc_en_o     = exitBeat;
  assign acc_clr_o    = exitBeat & first_q[STAGES-1];
  assign busy_o       = (state_q != IDLE);
  assign done_o       = jobDone;

  always_comb begin
    stg_en_o    = '0;
    stg_en_o[0] = accept;
    for (int i = 1; i < STAGES; i++) begin
      stg_en_o[i] = advance & vld_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    passes_d    = passes_q;
    outputs_d   = outputs_q;
    beat_d      = beat_q;
    pix_d       = pix_q;
    vld_d       = vld_q;
    first_d     = first_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;

    if (advance) begin
      vld_d[0]   = accept;
      first_d[0] = accept & (beat_q == '0);
      last_d[0]  = accept & lastOfPixel;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i]   = vld_q[i-1];
        first_d[i] = first_q[i-1];
        last_d[i]  = last_q[i-1];
      end
    end

    // Clear on consume first so a last beat exiting the same cycle re-arms it.
    if (out_valid_q & hs.out_ready) out_valid_d = 1'b0;
    if (exitBeat & last_q[STAGES-1]) out_valid_d = 1'b1;

    if (accept) begin
      if (lastOfPixel) begin
        beat_d = '0;
        pix_d  = pix_q + OUT_ONE;
      end else begin
        beat_d = beat_q + PASS_ONE;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = RUN;
          passes_d  = (cfg_passes_i == '0) ? PASS_ONE : cfg_passes_i;
          outputs_d = (cfg_outputs_i == '0) ? OUT_ONE : cfg_outputs_i;
          beat_d    = '0;
          pix_d     = '0;
        end
      end
      RUN:     if (finalBeat) state_d = DRAIN;
      DRAIN:   if (jobDone) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (kill) begin
      state_d     = IDLE;
      vld_d       = '0;
      first_d     = '0;
      last_d      = '0;
      out_valid_d = 1'b0;
      beat_d      = '0;
      pix_d       = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      passes_q    <= '0;
      outputs_q   <= '0;
      beat_q      <= '0;
      pix_q       <= '0;
      vld_q       <= '0;
      first_q     <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      passes_q    <= passes_d;
      outputs_q   <= outputs_d;
      beat_q      <= beat_d;
      pix_q       <= pix_d;
      vld_q       <= vld_d;
      first_q     <= first_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef ADDERTREE_CTRL_PERF_EN
  logic [31:0] perf_active_q, perf_stall_q;

  // Counters freeze once the job leaves busy and restart only on an accepted start.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      perf_active_q <= '0;
      perf_stall_q  <= '0;
    end else if ((state_q == IDLE) && start_i && !abort_i) begin
      perf_active_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (busy_o && (perf_active_q != '1)) perf_active_q <= perf_active_q + 32'd1;
      if (busy_o && stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_active_o = perf_active_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_addertree_ctrl.sv
// Self-checking bench for addertree_ctrl: directed and random jobs compared each cycle
// against a beat-queue model of the adder tree (optional perf checks with ADDERTREE_CTRL_PERF_EN).
module tb_addertree_ctrl;
  localparam int STAGES = 3;
  localparam int PASS_W = 8;
  localparam int OUT_W  = 12;
  localparam int BUDGET = 4000;

  typedef struct {
    int age;
    bit first;
    bit last;
  } beat_t;

  logic              clk;
  logic              resetN;
  logic              startIn;
  logic              abortIn;
  logic [PASS_W-1:0] cfgPasses;
  logic [OUT_W-1:0]  cfgOutputs;
  logic [STAGES-1:0] stgEn;
  logic              accClr;
  logic              accEn;
  logic              busy;
  logic              done;
`ifdef ADDERTREE_CTRL_PERF_EN
  logic [31:0]       perfActive;
  logic [31:0]       perfStall;
`endif

  addertree_ctrl_if hs();

  addertree_ctrl #(.STAGES(STAGES), .PASS_W(PASS_W), .OUT_W(OUT_W)) dut (
    .clk_i         (clk),
    .reset_n_i     (resetN),
    .start_i       (startIn),
    .abort_i       (abortIn),
    .cfg_passes_i  (cfgPasses),
    .cfg_outputs_i (cfgOutputs),
    .hs            (hs),
    .stg_en_o      (stgEn),
    .acc_clr_o     (accClr),
    .acc_en_o      (accEn),
    .busy_o        (busy),
    .done_o        (done)
`ifdef ADDERTREE_CTRL_PERF_EN
    ,
    .perf_active_o (perfActive),
    .perf_stall_o  (perfStall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model: a job is a total beat count; beats in flight are a queue of ages.
  beat_t pipeQ[$];
  bit    mBusy;
  bit    mDrain;
  bit    mOutValid;
  int    mPasses;
  int    mTotal;
  int    mAccepted;
  int    mPerfActive;
  int    mPerfStall;
  int    dutPix;
  int    dutBeats;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hasAge(input int a);
    foreach (pipeQ[i]) if (pipeQ[i].age == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic applyStimulus(input bit inV, input bit outR, input bit st, input bit ab,
                               input bit rn, input int p, input int o);
    bit kill, adv, acc, exitNow, exitFirst, exitLast, expDone, wasBusy;
    logic [STAGES-1:0] expStg;
    beat_t nb;
    @(negedge clk);
    hs.in_valid  = inV;
    hs.out_ready = outR;
    startIn      = st;
    abortIn      = ab;
    resetN       = rn;
    cfgPasses    = p[PASS_W-1:0];
    cfgOutputs   = o[OUT_W-1:0];
    #1;
    kill      = ab || !rn;
    adv       = !(mOutValid && !outR);
    acc       = inV && mBusy && !mDrain && adv && !kill;
    exitNow   = 1'b0;
    exitFirst = 1'b0;
    exitLast  = 1'b0;
    foreach (pipeQ[i]) begin
      if (pipeQ[i].age == STAGES - 1) begin
        exitNow   = adv;
        exitFirst = pipeQ[i].first;
        exitLast  = pipeQ[i].last;
      end
    end
    expStg    = '0;
    expStg[0] = acc;
    for (int s = 1; s < STAGES; s++) expStg[s] = adv && hasAge(s - 1);
    expDone = mDrain && (pipeQ.size() == 0) && (!mOutValid || outR) && !kill;

    checkOutput("in_ready", hs.in_ready, acc || (mBusy && !mDrain && adv && !kill));
    checkOutput("stg_en", stgEn, expStg);
    checkOutput("acc_en", accEn, exitNow);
    checkOutput("acc_clr", accClr, exitNow && exitFirst);
    checkOutput("out_valid", hs.out_valid, mOutValid);
    checkOutput("busy", busy, mBusy);
    checkOutput("done", done, expDone);
    if (hs.out_valid === 1'b1 && outR) dutPix++;
    if (stgEn[0] === 1'b1) dutBeats++;

    @(posedge clk);
    wasBusy = mBusy;
    if (!rn) begin
      mPerfActive = 0;
      mPerfStall  = 0;
    end else if (!wasBusy && st && !ab) begin
      mPerfActive = 0;
      mPerfStall  = 0;
    end else begin
      if (wasBusy) mPerfActive++;
      if (wasBusy && !adv) mPerfStall++;
    end

    if (kill) begin
      pipeQ.delete();
      mOutValid = 1'b0;
      mBusy     = 1'b0;
      mDrain    = 1'b0;
      mAccepted = 0;
    end else begin
      if (adv) begin
        foreach (pipeQ[i]) pipeQ[i].age++;
        while (pipeQ.size() > 0 && pipeQ[0].age == STAGES) void'(pipeQ.pop_front());
      end
      if (acc) begin
        nb.age   = 0;
        nb.first = (mAccepted % mPasses) == 0;
        nb.last  = (mAccepted % mPasses) == mPasses - 1;
        pipeQ.push_back(nb);
        mAccepted++;
      end
      if (mOutValid && outR) mOutValid = 1'b0;
      if (exitNow && exitLast) mOutValid = 1'b1;
      if (expDone) begin
        mBusy  = 1'b0;
        mDrain = 1'b0;
      end else if (acc && mAccepted == mTotal) begin
        mDrain = 1'b1;
      end
      if (!wasBusy && st) begin
        mBusy     = 1'b1;
        mDrain    = 1'b0;
        mPasses   = (p == 0) ? 1 : p;
        mTotal    = mPasses * ((o == 0) ? 1 : o);
        mAccepted = 0;
      end
    end
  endtask

  // vMode: 0 always valid, 1 alternating, 2 random. rMode: 0 always ready, 1 random, 2 one 5-cycle stall.
  // killKind: 1 abort, 2 reset_n low, at cycle killAt. restartAt pulses start with cfg rp/ro.
  task automatic runJob(input string name, input int p, input int o, input int vMode, input int rMode,
                        input int killAt, input int killKind, input int restartAt,
                        input int rp, input int ro);
    int cyc, stallLeft, effP, effO;
    bit inV, outR, st, ab, rn, interrupted;
    effP        = (p == 0) ? 1 : p;
    effO        = (o == 0) ? 1 : o;
    dutPix      = 0;
    dutBeats    = 0;
    stallLeft   = 5;
    interrupted = 1'b0;
    $display("[TB] job %s passes=%0d outputs=%0d", name, p, o);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, p, o);
    cyc = 1;
    while (mBusy && cyc < BUDGET) begin
      case (vMode)
        0:       inV = 1'b1;
        1:       inV = cyc[0];
        default: inV = 1'($urandom_range(0, 1));
      endcase
      case (rMode)
        0: outR = 1'b1;
        1: outR = ($urandom_range(0, 3) != 0);
        default: begin
          if (mOutValid && stallLeft > 0) begin
            outR = 1'b0;
            stallLeft--;
          end else begin
            outR = 1'b1;
          end
        end
      endcase
      ab = (killKind == 1) && (cyc == killAt);
      rn = !((killKind == 2) && (cyc == killAt));
      st = (cyc == restartAt);
      applyStimulus(inV, outR, st, ab, rn, st ? rp : p, st ? ro : o);
      if (cyc == killAt) interrupted = 1'b1;
      cyc++;
    end
    checkOutput({name, ".finished"}, 32'(cyc < BUDGET), 32'd1);
    if (!interrupted) begin
      checkOutput({name, ".pixels"}, dutPix, effO);
      checkOutput({name, ".beats"}, dutBeats, effP * effO);
`ifdef ADDERTREE_CTRL_PERF_EN
      checkOutput({name, ".perf_active"}, perfActive, mPerfActive);
      checkOutput({name, ".perf_stall"}, perfStall, mPerfStall);
`endif
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, p, o);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    mBusy        = 1'b0;
    mDrain       = 1'b0;
    mOutValid    = 1'b0;
    mPasses      = 1;
    mTotal       = 1;
    mAccepted    = 0;
    mPerfActive  = 0;
    mPerfStall   = 0;
    resetN       = 1'b0;
    startIn      = 1'b0;
    abortIn      = 1'b0;
    cfgPasses    = '0;
    cfgOutputs   = '0;
    hs.in_valid  = 1'b0;
    hs.out_ready = 1'b1;
    repeat (3) @(posedge clk);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);

    runJob("basic",        4, 2, 0, 0, -1, 0, -1, 0, 0);
    runJob("zeroCfg",      0, 0, 0, 0, -1, 0, -1, 0, 0);
    runJob("stall5",       2, 3, 0, 2, -1, 0, -1, 0, 0);
    runJob("bubbles",      2, 2, 1, 0, -1, 0, -1, 0, 0);
    runJob("abort",        4, 4, 0, 0,  3, 1, -1, 0, 0);
    runJob("afterAbort",   4, 2, 0, 0, -1, 0, -1, 0, 0);
    runJob("restartIgn",   3, 2, 0, 1, -1, 0,  2, 5, 5);
    runJob("midReset",     3, 3, 2, 1,  6, 2, -1, 0, 0);
    runJob("afterReset",   1, 5, 0, 1, -1, 0, -1, 0, 0);
    for (int j = 0; j < 6; j++) begin
      runJob("random", $urandom_range(0, 5), $urandom_range(0, 4), 2, 1, -1, 0, -1, 0, 0);
    end
    runJob("randAbort", 5, 3, 2, 1, 9, 1, -1, 0, 0);
    runJob("final",     2, 2, 0, 0, -1, 0, -1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
